mux8_bus_arbiter: RTL
=====================

Name: mux8_bus_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit bus among 8 requesters.
- The bus is built from the team's 8:1 32-bit mux; this block drives that mux's 3-bit select and tells each requester when it owns the bus.
- Supports multi-beat ownership: a requester holds the bus until it signals its last beat or stalls too long.
- Sits between the pipeline-side requesters (fetch, load/store, debug, DMA, ...) and a single shared target port.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the 3-bit mux select.
- TIMEOUT, 16, idle cycles a granted requester may hold the bus with req low before its grant is revoked; legal range 1..255.
- CNT_W, 8, width of the timeout and beat counters.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, 8, per-requester bus request; bit i belongs to mux input Ii.
- last, input, 8, per-requester "this beat is the final one"; sampled only for the current owner.
- tgt_ready, input, 1, shared target accepts the current beat.
- s, output, 3, select to the 8:1 mux; index of the current owner.
- gnt, output, 8, one-hot grant; all-zero when no owner.
- bus_valid, output, 1, current owner is presenting a beat on the mux output.
- beat_cnt, output, 8, beats completed in the current tenure; saturates at 255.
- timeout_evt, output, 1, one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async assert, sync release): state IDLE, gnt=0, s=0, bus_valid=0, beat_cnt=0, timeout_evt=0, priority pointer ptr=0.
- All outputs are registered except bus_valid, which is combinational: gnt[s] & req[s].
- The FSM has two states, IDLE and OWN.
- IDLE:
  - If req != 0, the winner is the first set bit at or after ptr, searched in order ptr, ptr+1 .. 7, 0 .. ptr-1 (mod 8).
  - Next cycle: state OWN, s=winner, gnt=1<<winner, beat_cnt=0, timeout counter=0.
  - If req == 0, stay in IDLE with all outputs held at 0 except s, which keeps its last value.
- Grant latency is exactly 1 cycle from req seen in IDLE to gnt asserted.
- OWN, in priority order:
  1. Release: a beat transfers when bus_valid & tgt_ready.
     - On each transfer, beat_cnt increments and saturates at 255.
     - If last[s] is high on the transfer, then next cycle: gnt=0, state IDLE, ptr=s+1 (wraps 7 to 0).
  2. Timeout: if req[s]=0, the timeout counter increments; any cycle with req[s]=1 clears it.
     - When the counter reaches TIMEOUT-1 with req[s] still low, then next cycle: gnt=0, state IDLE, ptr=s+1, timeout_evt=1 for one cycle.
  3. Otherwise hold: s and gnt stay unchanged. Requests from other requesters are ignored (no preemption).
- The mandatory IDLE bubble after release means there is at least 1 cycle with gnt=0 between tenures. This is intentional: it gives the mux select a settle cycle.
- last is ignored when no transfer occurs. last on a non-owner bit has no effect.
- tgt_ready with bus_valid=0 is not a transfer.
- If req[s] drops on the same cycle as a last transfer, release wins; no timeout is counted.
- ptr advances only on release or timeout, never on idle cycles.
- Fairness: with all 8 requesting continuously, each requester owns the bus exactly once every 8 tenures.
- Reset asserted mid-tenure drops gnt and bus_valid immediately (async). No beat is considered transferred on that cycle.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=1'b0, OWN=1'b1);
  - N_REQ=8 and SEL_W=3;
  - the TIMEOUT default.
- One natural sub-module, rr_pick8: purely combinational, takes req[7:0] and ptr[2:0] and returns winner[2:0] plus any.
  - Implement it as a doubled-vector priority scan.
  - It is reusable by the register-file port scheduler.
- The 8:1 32-bit mux itself is instantiated outside this block, at the bus top level.

Test Plan:
- Single requester:
  - Stimulus: after reset, req=8'b0000_0100; 3 beats with tgt_ready=1 and last high on the 3rd.
  - Response: gnt=8'h04 and s=2 one cycle after req; beat_cnt goes 1, 2, 3; gnt=0 the cycle after the last beat; ptr=3.
- Round-robin:
  - Stimulus: req=8'hFF held, every tenure is one beat with last=1.
  - Response: s sequence 0, 1, 2 .. 7, 0, with one gnt=0 bubble between consecutive grants.
- Pointer wrap:
  - Stimulus: ptr=6 (after an s=5 tenure), req=8'b1000_0011.
  - Response: winner is s=7, then s=0, then s=1.
- Stall:
  - Stimulus: owner s=4 with tgt_ready=0 for 20 cycles, req[4] held.
  - Response: gnt stays 8'h10 and beat_cnt stays 0; no timeout_evt.
- Timeout:
  - Stimulus: owner s=1, req[1] dropped, TIMEOUT=16.
  - Response: gnt=0 and timeout_evt=1 on the 16th cycle after the drop; the next grant goes to the next requester from 2 upward.
- Async reset:
  - Stimulus: rst_n pulled low mid-tenure (s=3, beat_cnt=2).
  - Response: gnt=0, bus_valid=0, beat_cnt=0 without waiting for clk. After release, the first request scan starts from ptr=0.

Source files
------------

// File: rtl/mux8_bus_arbiter_pkg.sv
// Shared definitions for the 8-requester round-robin bus arbiter.
package mux8_bus_arbiter_pkg;

   localparam int unsigned N_REQ       = 8;
   localparam int unsigned SEL_W       = 3;
   localparam int unsigned TIMEOUT_DEF = 16;
   localparam int unsigned CNT_W_DEF   = 8;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

endpackage

// File: rtl/mux8_bus_arbiter_rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick8
   import mux8_bus_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] winner,
   output logic             any
);

   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   // Doubled-vector scan: rotate req so req[ptr] lands in bit 0, take the lowest set bit.
   always_comb begin
      rot = N_REQ'({req, req} >> ptr);
      off = '0;
      for (int unsigned i = N_REQ; i > 0; i--) begin
         if (rot[i-1]) off = SEL_W'(i - 1);
      end
      winner = ptr + off;
      any    = |req;
   end

endmodule

// File: rtl/mux8_bus_arbiter.sv
// Round-robin owner arbiter for a shared 32-bit bus built from an 8:1 mux.
// Drives the mux select and a one-hot grant; owners keep the bus for a
// multi-beat tenure until a last beat transfers or they idle past TIMEOUT.
module mux8_bus_arbiter
   import mux8_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] last,
   input  logic             tgt_ready,
   output logic [SEL_W-1:0] s,
   output logic [N_REQ-1:0] gnt,
   output logic             bus_valid,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             timeout_evt
);

   state_t           state, state_nxt;
   logic [SEL_W-1:0] ptr, ptr_nxt, s_nxt, winner;
   logic [N_REQ-1:0] gnt_nxt;
   logic [CNT_W-1:0] beat_nxt, tcnt, tcnt_nxt;
   logic             tevt_nxt, any, xfer;

   rr_pick8 u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (winner),
      .any    (any)
   );

   // Owner presents a beat whenever it is granted and still requesting.
   always_comb begin
      bus_valid = gnt[s] & req[s];
      xfer      = bus_valid & tgt_ready;
   end

   // Next-state logic: pick in IDLE; in OWN release on last beat, else count idle cycles.
   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      gnt_nxt   = gnt;
      beat_nxt  = beat_cnt;
      tcnt_nxt  = tcnt;
      ptr_nxt   = ptr;
      tevt_nxt  = 1'b0;
      case (state)
         IDLE: begin
            gnt_nxt  = '0;
            beat_nxt = '0;
            tcnt_nxt = '0;
            if (any) begin
               state_nxt = OWN;
               s_nxt     = winner;
               gnt_nxt   = N_REQ'(1) << winner;
            end
         end
         OWN: begin
            if (xfer && (beat_cnt != '1)) beat_nxt = beat_cnt + CNT_W'(1);
            if (xfer && last[s]) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               ptr_nxt   = s + SEL_W'(1);
               tcnt_nxt  = '0;
            end else if (!req[s]) begin
               if (tcnt == CNT_W'(TIMEOUT - 1)) begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
                  ptr_nxt   = s + SEL_W'(1);
                  tcnt_nxt  = '0;
                  tevt_nxt  = 1'b1;
               end else begin
                  tcnt_nxt = tcnt + CNT_W'(1);
               end
            end else begin
               tcnt_nxt = '0;
            end
         end
      endcase
   end

   // State and output registers; reset clears everything including the priority pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         s           <= '0;
         gnt         <= '0;
         beat_cnt    <= '0;
         tcnt        <= '0;
         ptr         <= '0;
         timeout_evt <= 1'b0;
      end else begin
         state       <= state_nxt;
         s           <= s_nxt;
         gnt         <= gnt_nxt;
         beat_cnt    <= beat_nxt;
         tcnt        <= tcnt_nxt;
         ptr         <= ptr_nxt;
         timeout_evt <= tevt_nxt;
      end
   end

endmodule
